// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Memory-access stage plus MEM/WB pipeline register for the 5-stage MIPS
//   pipeline. It issues the data-cache request for the instruction held in
//   EX/MEM and holds that request until dhit. It stalls the upstream stages
//   while the access is outstanding. A small IDLE/BUSY/DONE FSM makes sure
//   each instruction touches the cache exactly once. On each advance the
//   stage latches the write-back value, the destination register and halt.
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   pipe_en               global advance enable from the hazard unit
//   flush                 turn the instruction entering WB into a bubble
//   valid_in .. halt_in   EX/MEM latch contents (control, data, destination)
//   dhit, dmemload        data-cache completion and load data
//   dmemREN/WEN/addr/store data-cache request
//   mem_stall             freeze IF..EX/MEM while the access is outstanding
//   wb_RegWr/wsel/wdat    registered write-back port
//   wb_valid              WB holds a real instruction
//   halt_out              sticky halt, cleared only by reset
module mem_wb_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              pipe_en,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic [WORD_W-1:0] alu_in,
  input  logic [WORD_W-1:0] rdat2_in,
  input  logic              RegWr_in,
  input  logic              MemtoReg_in,
  input  logic              jal_in,
  input  logic              lui_in,
  input  logic [15:0]       imm_in,
  input  logic [WORD_W-1:0] pcplusfour_in,
  input  logic [REG_W-1:0]  wsel_in,
  input  logic              halt_in,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              wb_RegWr,
  output logic [REG_W-1:0]  wb_wsel,
  output logic [WORD_W-1:0] wb_wdat,
  output logic              wb_valid,
  output logic              halt_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   ldBuf_q, ldBuf_d;
  logic                wbValid_q, wbValid_d;
  logic                wbRegWr_q, wbRegWr_d;
  logic [REG_W-1:0]    wbWsel_q, wbWsel_d;
  logic [WORD_W-1:0]   wbWdat_q, wbWdat_d;
  logic                halt_q, halt_d;

  logic                memOp;
  logic                reqActive;
  logic                adv;
  logic [WORD_W-1:0]   ldSrc;
  logic [WORD_W-1:0]   luiVal;

  // Once halted, the stage issues no more requests. In DONE the access
  // has already happened, so the request must not be reissued. The RST
  // term keeps the request and stall low for the whole reset pulse.
  always_comb begin
    memOp     = valid_in & (dREN_in | dWEN_in) & ~halt_q;
    reqActive = memOp & (state_q != DONE) & ~RST;
    dmemREN   = reqActive & dREN_in;
    dmemWEN   = reqActive & dWEN_in & ~dREN_in;
    dmemaddr  = alu_in;
    dmemstore = rdat2_in;
    mem_stall = reqActive & ~dhit;
    adv       = pipe_en & ~mem_stall;
    ldSrc     = (state_q == DONE) ? ldBuf_q : dmemload;
    luiVal    = WORD_W'({imm_in, 16'h0000});
  end

  // The FSM enters DONE only when the access finishes while the pipe is
  // frozen. It latches the load data then, because the cache may drive
  // dmemload with something else on later cycles.
  always_comb begin
    state_d = state_q;
    ldBuf_d = ldBuf_q;
    case (state_q)
      IDLE: begin
        if (memOp && !dhit) begin
          state_d = BUSY;
        end else if (memOp && dhit && !pipe_en) begin
          state_d = DONE;
          ldBuf_d = dmemload;
        end
      end
      BUSY: begin
        if (dhit) begin
          if (pipe_en) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            ldBuf_d = dmemload;
          end
        end
      end
      DONE: begin
        if (pipe_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // MEM/WB register update. The write-back mux priority is
  // load > jal > lui > ALU.
  always_comb begin
    wbValid_d = wbValid_q;
    wbRegWr_d = wbRegWr_q;
    wbWsel_d  = wbWsel_q;
    wbWdat_d  = wbWdat_q;
    halt_d    = halt_q;
    if (adv) begin
      wbValid_d = valid_in & ~flush;
      wbRegWr_d = RegWr_in & valid_in & ~flush;
      wbWsel_d  = wsel_in;
      if (MemtoReg_in)  wbWdat_d = ldSrc;
      else if (jal_in)  wbWdat_d = pcplusfour_in;
      else if (lui_in)  wbWdat_d = luiVal;
      else              wbWdat_d = alu_in;
      if (halt_in && valid_in && !flush) halt_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      ldBuf_q   <= '0;
      wbValid_q <= 1'b0;
      wbRegWr_q <= 1'b0;
      wbWsel_q  <= '0;
      wbWdat_q  <= '0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ldBuf_q   <= ldBuf_d;
      wbValid_q <= wbValid_d;
      wbRegWr_q <= wbRegWr_d;
      wbWsel_q  <= wbWsel_d;
      wbWdat_q  <= wbWdat_d;
      halt_q    <= halt_d;
    end
  end

  assign wb_valid = wbValid_q;
  assign wb_RegWr = wbRegWr_q;
  assign wb_wsel  = wbWsel_q;
  assign wb_wdat  = wbWdat_q;
  assign halt_out = halt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
//   Self-checking bench for mem_wb_stage. The reference model keeps two
//   facts about the instruction in EX/MEM: whether its cache access has
//   already completed, and the data that came back. From these it derives
//   the request, the stall, the advance and the WB contents. The bench runs
//   directed scenarios first and then randomized traffic. It holds each
//   instruction stable until the model says that instruction has advanced.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pipeEn, flushIn, validIn, dRenIn, dWenIn;
  logic [31:0] aluIn, rdat2In, pc4In, dmemLoad;
  logic        regWrIn, memToRegIn, jalIn, luiIn, haltIn, dhit;
  logic [15:0] immIn;
  logic [4:0]  wselIn;

  logic        dmemREN, dmemWEN, memStall, wbRegWr, wbValid, haltOut;
  logic [31:0] dmemAddr, dmemStore, wbWdat;
  logic [4:0]  wbWsel;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference model state
  logic        mServiced, mHalt, mWbValid, mWbRegWr, lastAdv;
  logic [31:0] mLd, mWbWdat;
  logic [4:0]  mWbWsel;

  mem_wb_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .pipe_en(pipeEn), .flush(flushIn),
    .valid_in(validIn), .dREN_in(dRenIn), .dWEN_in(dWenIn),
    .alu_in(aluIn), .rdat2_in(rdat2In), .RegWr_in(regWrIn),
    .MemtoReg_in(memToRegIn), .jal_in(jalIn), .lui_in(luiIn),
    .imm_in(immIn), .pcplusfour_in(pc4In), .wsel_in(wselIn),
    .halt_in(haltIn), .dhit(dhit), .dmemload(dmemLoad),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemAddr),
    .dmemstore(dmemStore), .mem_stall(memStall), .wb_RegWr(wbRegWr),
    .wb_wsel(wbWsel), .wb_wdat(wbWdat), .wb_valid(wbValid),
    .halt_out(haltOut)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mServiced = 1'b0; mHalt = 1'b0; mWbValid = 1'b0; mWbRegWr = 1'b0;
    mLd = '0; mWbWdat = '0; mWbWsel = '0;
  endtask

  task automatic clearInstr();
    validIn = 1'b0; dRenIn = 1'b0; dWenIn = 1'b0; regWrIn = 1'b0;
    memToRegIn = 1'b0; jalIn = 1'b0; luiIn = 1'b0; haltIn = 1'b0;
    aluIn = '0; rdat2In = '0; pc4In = '0; immIn = '0; wselIn = '0;
    flushIn = 1'b0;
  endtask

  task automatic randomInstr(input bit allowHalt);
    int kind;
    clearInstr();
    validIn = ($urandom_range(0, 9) != 0);
    kind    = $urandom_range(0, 5);
    aluIn   = $urandom; rdat2In = $urandom; pc4In = $urandom;
    immIn   = 16'($urandom); wselIn = 5'($urandom);
    case (kind)
      0: begin dRenIn = 1'b1; memToRegIn = 1'b1; regWrIn = 1'b1; end
      1: dWenIn = 1'b1;
      2: begin dRenIn = 1'b1; dWenIn = 1'b1; memToRegIn = 1'b1; regWrIn = 1'b1; end
      3: begin jalIn = 1'b1; regWrIn = 1'b1; luiIn = 1'($urandom); end
      4: begin luiIn = 1'b1; regWrIn = 1'b1; end
      default: regWrIn = 1'($urandom);
    endcase
    if (allowHalt && $urandom_range(0, 59) == 0) haltIn = 1'b1;
  endtask

  // One clock: inputs are already driven. Combinational outputs are
  // checked on the falling edge, the model is advanced, and the registered
  // outputs are checked just after the rising edge.
  task automatic applyStimulus();
    logic        memOp, expReq, expStall, adv;
    logic [31:0] wdat;
    @(negedge CLK);
    memOp    = validIn & (dRenIn | dWenIn) & ~mHalt;
    expReq   = memOp & ~mServiced;
    expStall = expReq & ~dhit;
    checkOutput("dmemREN", 32'(dmemREN), 32'(expReq & dRenIn));
    checkOutput("dmemWEN", 32'(dmemWEN), 32'(expReq & dWenIn & ~dRenIn));
    checkOutput("dmemaddr", dmemAddr, aluIn);
    checkOutput("dmemstore", dmemStore, rdat2In);
    checkOutput("mem_stall", 32'(memStall), 32'(expStall));
    adv = pipeEn & ~expStall;
    if (memToRegIn)  wdat = mServiced ? mLd : dmemLoad;
    else if (jalIn)  wdat = pc4In;
    else if (luiIn)  wdat = {immIn, 16'h0000};
    else             wdat = aluIn;
    if (adv) begin
      mWbValid  = validIn & ~flushIn;
      mWbRegWr  = regWrIn & validIn & ~flushIn;
      mWbWsel   = wselIn;
      mWbWdat   = wdat;
      mServiced = 1'b0;
      if (haltIn && validIn && !flushIn) mHalt = 1'b1;
    end else if (expReq && dhit) begin
      mServiced = 1'b1;
      mLd       = dmemLoad;
    end
    lastAdv = adv;
    @(posedge CLK);
    #1;
    checkOutput("wb_valid", 32'(wbValid), 32'(mWbValid));
    checkOutput("wb_RegWr", 32'(wbRegWr), 32'(mWbRegWr));
    checkOutput("wb_wsel", 32'(wbWsel), 32'(mWbWsel));
    checkOutput("wb_wdat", wbWdat, mWbWdat);
    checkOutput("halt_out", 32'(haltOut), 32'(mHalt));
  endtask

  task automatic randomPhase(input int cycles, input bit allowHalt);
    lastAdv = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (lastAdv) randomInstr(allowHalt);
      pipeEn   = ($urandom_range(0, 9) < 7);
      dhit     = 1'($urandom);
      flushIn  = ($urandom_range(0, 9) == 0);
      dmemLoad = $urandom;
      applyStimulus();
    end
  endtask

  initial begin
    clearInstr();
    pipeEn = 1'b1; dhit = 1'b0; dmemLoad = '0; lastAdv = 1'b0;
    modelReset();

    // Reset with a load presented: no request and no stall while RST is high
    RST = 1'b1;
    validIn = 1'b1; dRenIn = 1'b1; memToRegIn = 1'b1; regWrIn = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst dmemREN", 32'(dmemREN), 32'd0);
    checkOutput("rst mem_stall", 32'(memStall), 32'd0);
    checkOutput("rst wb_valid", 32'(wbValid), 32'd0);
    checkOutput("rst wb_wdat", wbWdat, 32'd0);
    checkOutput("rst halt_out", 32'(haltOut), 32'd0);
    RST = 1'b0;

    // Load at 0x100 that misses three cycles, then hits
    aluIn = 32'h100; wselIn = 5'd3;
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3);
      dmemLoad = (i == 3) ? 32'hDEADBEEF : 32'h0;
      applyStimulus();
    end
    checkOutput("lw miss wdat", wbWdat, 32'hDEADBEEF);
    checkOutput("lw miss RegWr", 32'(wbRegWr), 32'd1);

    // Store that hits at once while the pipe is frozen for two cycles
    clearInstr();
    validIn = 1'b1; dWenIn = 1'b1; aluIn = 32'h200; rdat2In = 32'h1234;
    pipeEn = 1'b0; dhit = 1'b1; applyStimulus();
    dhit = 1'b0; applyStimulus();
    checkOutput("sw held no WEN", 32'(dmemWEN), 32'd0);
    pipeEn = 1'b1; applyStimulus();
    checkOutput("sw RegWr", 32'(wbRegWr), 32'd0);
    checkOutput("sw valid", 32'(wbValid), 32'd1);

    // Load data must come from the hit cycle, not from later dmemload
    clearInstr();
    validIn = 1'b1; dRenIn = 1'b1; memToRegIn = 1'b1; regWrIn = 1'b1;
    wselIn = 5'd9; pipeEn = 1'b0; dhit = 1'b1; dmemLoad = 32'hCAFEF00D;
    applyStimulus();
    dhit = 1'b0; dmemLoad = 32'h0; pipeEn = 1'b1; applyStimulus();
    checkOutput("lw buffered wdat", wbWdat, 32'hCAFEF00D);

    // Write-back mux for instructions that do not access memory
    clearInstr();
    validIn = 1'b1; jalIn = 1'b1; regWrIn = 1'b1; pc4In = 32'h44; wselIn = 5'd31;
    applyStimulus();
    checkOutput("jal wdat", wbWdat, 32'h44);
    clearInstr();
    validIn = 1'b1; luiIn = 1'b1; regWrIn = 1'b1; immIn = 16'hABCD;
    applyStimulus();
    checkOutput("lui wdat", wbWdat, 32'hABCD0000);
    flushIn = 1'b1; applyStimulus();
    checkOutput("flush RegWr", 32'(wbRegWr), 32'd0);
    checkOutput("flush valid", 32'(wbValid), 32'd0);

    randomPhase(300, 1'b0);

    // Reset while a load is outstanding
    clearInstr();
    validIn = 1'b1; dRenIn = 1'b1; memToRegIn = 1'b1; regWrIn = 1'b1;
    wselIn = 5'd7; aluIn = 32'h1; pipeEn = 1'b1; dhit = 1'b1; dmemLoad = 32'h55;
    applyStimulus();
    dhit = 1'b0; aluIn = 32'h300; applyStimulus();
    checkOutput("busy dmemREN", 32'(dmemREN), 32'd1);
    RST = 1'b1;
    #1;
    checkOutput("mid rst dmemREN", 32'(dmemREN), 32'd0);
    checkOutput("mid rst mem_stall", 32'(memStall), 32'd0);
    checkOutput("mid rst wb_RegWr", 32'(wbRegWr), 32'd0);
    checkOutput("mid rst wb_wsel", 32'(wbWsel), 32'd0);
    checkOutput("mid rst wb_wdat", wbWdat, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    modelReset();
    dhit = 1'b1; dmemLoad = 32'h77; applyStimulus();

    randomPhase(400, 1'b1);

    // Halt, then a load that must not reach the cache
    clearInstr();
    validIn = 1'b1; haltIn = 1'b1; pipeEn = 1'b1; dhit = 1'b0;
    applyStimulus();
    checkOutput("halt set", 32'(haltOut), 32'd1);
    clearInstr();
    validIn = 1'b1; dRenIn = 1'b1; memToRegIn = 1'b1; regWrIn = 1'b1;
    applyStimulus();
    checkOutput("halt no REN", 32'(dmemREN), 32'd0);
    checkOutput("halt no stall", 32'(memStall), 32'd0);
    checkOutput("halt sticky", 32'(haltOut), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
